// File: rtl/ball_motion.sv
// Per-ball motion integrator: latches collision/hole events during the scan,
// then applies velocity, position, friction and sink sequencing once per frame.
module ball_motion #(
  parameter int INIT_X          = 100,
  parameter int INIT_Y          = 200,
  parameter int FRAC            = 6,
  parameter int FRICTION_PERIOD = 4,
  parameter int FRICTION_STEP   = 1,
  parameter int MAX_VEL         = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               collisionOccurred,
  input  logic signed [10:0] velXIn,
  input  logic signed [10:0] velYIn,
  input  logic               holeHit,
  input  logic        [2:0]  holeNum,
  input  logic               shotValid,
  input  logic signed [10:0] shotVelX,
  input  logic signed [10:0] shotVelY,
  input  logic               respawn,
  output logic signed [10:0] topLeftPosX,
  output logic signed [10:0] topLeftPosY,
  output logic signed [10:0] velX,
  output logic signed [10:0] velY,
  output logic               moving,
  output logic               inHole,
  output logic        [2:0]  holeNumOut,
  output logic               shotAccepted
);

  localparam int PW = 11 + FRAC;
  localparam int CW = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
  localparam logic [CW-1:0]        CNT_LAST = CW'(FRICTION_PERIOD - 1);
  localparam logic signed [10:0]   VMAX     = 11'(MAX_VEL);
  localparam logic signed [10:0]   FSTEP    = 11'(FRICTION_STEP);
  localparam logic signed [PW-1:0] INIT_PX  = PW'(INIT_X * (2 ** FRAC));
  localparam logic signed [PW-1:0] INIT_PY  = PW'(INIT_Y * (2 ** FRAC));

  typedef enum logic [1:0] {IDLE, MOVING, SUNK} state_t;

  state_t                state_q, state_d;
  logic signed [PW-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [10:0]    vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  col_vld_q, col_vld_d;
  logic signed [10:0]    col_vx_q, col_vx_d, col_vy_q, col_vy_d;
  logic                  hole_vld_q, hole_vld_d;
  logic [2:0]            hole_num_q, hole_num_d;
  logic [2:0]            hole_out_q, hole_out_d;
  logic                  shot_acc_q, shot_acc_d;
  logic signed [10:0]    vx_new, vy_new, vx_fric, vy_fric;

  function automatic logic signed [10:0] sat_vel(input logic signed [10:0] v);
    if (v > VMAX) return VMAX;
    else if (v < -VMAX) return -VMAX;
    return v;
  endfunction

  function automatic logic signed [10:0] apply_friction(input logic signed [10:0] v);
    if (v > FSTEP) return v - FSTEP;
    else if (v < -FSTEP) return v + FSTEP;
    return '0;
  endfunction

  // One guard bit detects overflow; clamp instead of wrapping.
  function automatic logic signed [PW-1:0] add_pos(input logic signed [PW-1:0] p,
                                                   input logic signed [10:0] v);
    logic signed [PW:0] sum;
    sum = {p[PW-1], p} + {{(FRAC + 1){v[10]}}, v};
    if (sum[PW] != sum[PW-1])
      return sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    return sum[PW-1:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    vel_x_d    = vel_x_q;
    vel_y_d    = vel_y_q;
    cnt_d      = cnt_q;
    col_vld_d  = col_vld_q;
    col_vx_d   = col_vx_q;
    col_vy_d   = col_vy_q;
    hole_vld_d = hole_vld_q;
    hole_num_d = hole_num_q;
    hole_out_d = hole_out_q;
    shot_acc_d = 1'b0;
    vx_new     = col_vld_q ? sat_vel(col_vx_q) : vel_x_q;
    vy_new     = col_vld_q ? sat_vel(col_vy_q) : vel_y_q;
    vx_fric    = apply_friction(vx_new);
    vy_fric    = apply_friction(vy_new);

    case (state_q)
      IDLE: begin
        if (shotValid) begin
          vel_x_d    = sat_vel(shotVelX);
          vel_y_d    = sat_vel(shotVelY);
          shot_acc_d = 1'b1;
          cnt_d      = '0;
          col_vld_d  = 1'b0;
          hole_vld_d = 1'b0;
          state_d    = MOVING;
        end
      end
      MOVING: begin
        if (startOfFrame) begin
          if (hole_vld_q) begin
            state_d    = SUNK;
            vel_x_d    = '0;
            vel_y_d    = '0;
            hole_out_d = hole_num_q;
            col_vld_d  = 1'b0;
            hole_vld_d = 1'b0;
          end else begin
            pos_x_d = add_pos(pos_x_q, vx_new);
            pos_y_d = add_pos(pos_y_q, vy_new);
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              vel_x_d = vx_fric;
              vel_y_d = vy_fric;
            end else begin
              cnt_d   = cnt_q + CW'(1);
              vel_x_d = vx_new;
              vel_y_d = vy_new;
            end
            if (vel_x_d == '0 && vel_y_d == '0) begin
              state_d    = IDLE;
              col_vld_d  = 1'b0;
              hole_vld_d = 1'b0;
            end else begin
              // Events coincident with the frame pulse open the next frame's latches.
              col_vld_d  = collisionOccurred;
              col_vx_d   = velXIn;
              col_vy_d   = velYIn;
              hole_vld_d = holeHit;
              hole_num_d = holeNum;
            end
          end
        end else begin
          if (collisionOccurred && !col_vld_q) begin
            col_vld_d = 1'b1;
            col_vx_d  = velXIn;
            col_vy_d  = velYIn;
          end
          if (holeHit && !hole_vld_q) begin
            hole_vld_d = 1'b1;
            hole_num_d = holeNum;
          end
        end
      end
      SUNK: begin
        if (respawn) begin
          pos_x_d = INIT_PX;
          pos_y_d = INIT_PY;
          vel_x_d = '0;
          vel_y_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pos_x_q    <= INIT_PX;
      pos_y_q    <= INIT_PY;
      vel_x_q    <= '0;
      vel_y_q    <= '0;
      cnt_q      <= '0;
      col_vld_q  <= 1'b0;
      col_vx_q   <= '0;
      col_vy_q   <= '0;
      hole_vld_q <= 1'b0;
      hole_num_q <= '0;
      hole_out_q <= '0;
      shot_acc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      vel_x_q    <= vel_x_d;
      vel_y_q    <= vel_y_d;
      cnt_q      <= cnt_d;
      col_vld_q  <= col_vld_d;
      col_vx_q   <= col_vx_d;
      col_vy_q   <= col_vy_d;
      hole_vld_q <= hole_vld_d;
      hole_num_q <= hole_num_d;
      hole_out_q <= hole_out_d;
      shot_acc_q <= shot_acc_d;
    end
  end

  assign topLeftPosX  = pos_x_q[PW-1:FRAC];
  assign topLeftPosY  = pos_y_q[PW-1:FRAC];
  assign velX         = vel_x_q;
  assign velY         = vel_y_q;
  assign moving       = (state_q == MOVING);
  assign inHole       = (state_q == SUNK);
  assign holeNumOut   = hole_out_q;
  assign shotAccepted = shot_acc_q;

endmodule
